// File: rtl/stepper_move_ctrl.sv
// Move sequencer for the stepper1 phase FSM: paces single-cycle step codes on
// `control`, tracks signed position and drops into FAULT on warnbit.
module stepper_move_ctrl #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             warnbit,
    output logic [1:0]       control,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [POS_W-1:0] position,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

    state_t           r_state;
    logic             r_dir;
    logic [DIV_W-1:0] r_period;
    logic [DIV_W-1:0] r_timer;
    logic [1:0]       r_control;
    logic             r_busy;
    logic             r_done;
    logic             r_fault;
    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_steps;

    logic             w_accept;
    logic             w_step_end;
    logic [CNT_W-1:0] w_steps_dec;
    logic [POS_W-1:0] w_pos_next;
    logic [DIV_W-1:0] w_period_eff;

    assign cmd_ready    = (r_state == S_IDLE) && !abort;
    assign w_accept     = cmd_valid && cmd_ready;
    // A non-hold control code means this edge closes a step cycle.
    assign w_step_end   = (r_control != 2'b00);
    assign w_steps_dec  = r_steps - CNT_W'(w_step_end);
    assign w_pos_next   = !w_step_end ? r_pos :
                          (r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1));
    assign w_period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_period  <= DIV_W'(1);
            r_timer   <= '0;
            r_control <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
            r_pos     <= '0;
            r_steps   <= '0;
        end else begin
            r_done    <= 1'b0;
            r_control <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dir    <= cmd_dir;
                        r_period <= w_period_eff;
                        r_timer  <= w_period_eff - DIV_W'(1);
                        r_steps  <= cmd_steps;
                        if (cmd_steps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A step that ends on this edge always counts, whatever else happens.
                    r_steps <= w_steps_dec;
                    r_pos   <= w_pos_next;
                    if (warnbit) begin
                        r_state <= S_FAULT;
                        r_busy  <= 1'b0;
                        r_fault <= 1'b1;
                    end else if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_steps_dec == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        if (r_timer == '0) begin
                            r_timer   <= r_period - DIV_W'(1);
                            r_control <= r_dir ? 2'b10 : 2'b01;
                        end else begin
                            r_timer <= r_timer - DIV_W'(1);
                        end
                    end
                end
                S_FAULT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign control    = r_control;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault      = r_fault;
    assign position   = r_pos;
    assign steps_left = r_steps;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl: expected step codes/cycles and done
// cycles are queued when a command is sent and consumed by a negedge monitor.
module tb_stepper_move_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        warnbit = 1'b0;
    logic [1:0]  control;
    logic        busy, done, fault;
    logic [15:0] position, steps_left;

    stepper_move_ctrl #(.CNT_W(16), .DIV_W(16), .POS_W(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .warnbit(warnbit), .control(control), .busy(busy),
        .done(done), .fault(fault), .position(position), .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } ev_t;

    ev_t         sq[$];
    int          dq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          steps_seen = 0;
    logic [15:0] exp_pos = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every non-hold control cycle and every done cycle must match the queue head.
    always @(negedge clk) begin
        if (control != 2'b00) begin
            steps_seen <= steps_seen + 1;
            if (sq.size() == 0) begin
                check("unexpected_step", {30'd0, control}, 32'd0);
            end else begin
                check("step_code", {30'd0, control}, {30'd0, sq[0].code});
                check("step_cycle", cyc, sq[0].cyc);
                void'(sq.pop_front());
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                check("done_cycle", cyc, dq[0]);
                void'(dq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic d, input logic [15:0] n, input logic [15:0] p,
                        input int nexp, input bit exp_done);
        int k = 0;
        int e0;
        int pe;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_dir = d;
        cmd_steps = n;
        cmd_period = p;
        tick();
        e0 = cyc;
        cmd_valid = 1'b0;
        pe = (p == 0) ? 1 : int'(p);
        for (int i = 1; i <= nexp; i++) sq.push_back('{d ? 2'b10 : 2'b01, e0 + i * pe});
        if (exp_done) dq.push_back((n == 0) ? e0 : e0 + int'(n) * pe + 1);
        exp_pos = d ? exp_pos + 16'(nexp) : exp_pos - 16'(nexp);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((sq.size() != 0 || dq.size() != 0 || busy) && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", sq.size() + dq.size(), 32'd0);
        tick();
    endtask

    task automatic wait_steps(input int target);
        int k = 0;
        while (steps_seen < target && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("step_wait_timeout", (steps_seen >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #2 reset = 1'b0;
        #20;
        check("rst_control", {30'd0, control}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_position", {16'd0, position}, 32'd0);
        check("rst_steps_left", {16'd0, steps_left}, 32'd0);
        reset = 1'b1;
        tick();
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Forward 4 steps, period 3
        send(1'b1, 16'd4, 16'd3, 4, 1'b1);
        check("busy_from_accept", {31'd0, busy}, 32'd1);
        check("ready_low_in_run", {31'd0, cmd_ready}, 32'd0);
        wait_idle(200);
        check("fwd_position", {16'd0, position}, {16'd0, exp_pos});
        check("fwd_steps_left", {16'd0, steps_left}, 32'd0);

        // Reverse 3 steps, period 0 -> back-to-back step cycles
        send(1'b0, 16'd3, 16'd0, 3, 1'b1);
        wait_idle(200);
        check("rev_position", {16'd0, position}, {16'd0, exp_pos});

        // Abort after 4 of 10 steps
        send(1'b1, 16'd10, 16'd2, 4, 1'b0);
        wait_steps(steps_seen + 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_control", {30'd0, control}, 32'd0);
        check("abort_steps_left", {16'd0, steps_left}, 32'd6);
        check("abort_position", {16'd0, position}, {16'd0, exp_pos});
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 8; i++) tick();

        // Fault after 2 of 5 steps
        send(1'b1, 16'd5, 16'd2, 2, 1'b0);
        wait_steps(steps_seen + 2);
        warnbit = 1'b1;
        tick();
        warnbit = 1'b0;
        check("fault_set", {31'd0, fault}, 32'd1);
        check("fault_control", {30'd0, control}, 32'd0);
        check("fault_busy", {31'd0, busy}, 32'd0);
        check("fault_steps_left", {16'd0, steps_left}, 32'd3);
        for (int i = 0; i < 4; i++) tick();
        check("fault_held", {31'd0, fault}, 32'd1);
        check("fault_ready", {31'd0, cmd_ready}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("fault_cleared", {31'd0, fault}, 32'd0);
        check("fault_exit_ready", {31'd0, cmd_ready}, 32'd1);
        check("fault_position", {16'd0, position}, {16'd0, exp_pos});

        // Reset between step pulses
        send(1'b1, 16'd6, 16'd4, 1, 1'b0);
        wait_steps(steps_seen + 1);
        reset = 1'b0;
        #1;
        exp_pos = '0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_position", {16'd0, position}, 32'd0);
        check("midrst_steps_left", {16'd0, steps_left}, 32'd0);
        check("midrst_control", {30'd0, control}, 32'd0);
        #3 reset = 1'b1;
        tick();
        send(1'b1, 16'd2, 16'd1, 2, 1'b1);
        wait_idle(100);
        check("post_rst_position", {16'd0, position}, {16'd0, exp_pos});

        // Zero-step command
        send(1'b1, 16'd0, 16'd5, 0, 1'b1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        wait_idle(50);
        check("zero_steps_left", {16'd0, steps_left}, 32'd0);

        // Abort wins over cmd_valid in IDLE
        abort = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir = 1'b1;
        cmd_steps = 16'd3;
        cmd_period = 16'd1;
        #1;
        check("abort_idle_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        abort = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("abort_idle_position", {16'd0, position}, {16'd0, exp_pos});

        // Run to 0x7FFF then one more forward step wraps to 0x8000
        send(1'b1, 16'h7FFF - exp_pos, 16'd1, int'(16'h7FFF - exp_pos), 1'b1);
        wait_idle(40000);
        check("pos_7fff", {16'd0, position}, 32'h7FFF);
        send(1'b1, 16'd1, 16'd1, 1, 1'b1);
        wait_idle(100);
        check("pos_wrap", {16'd0, position}, 32'h8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
